shield_edf_n: RTL and testbench
===============================

# shield_edf_n

Parametrised runtime safety shield for N request/grant channels. It sits between the controlled system and the plant, with the same combinational pass-through-or-correct role as the per-DFA shields. It enforces three properties: mutual exclusion of grants, no spurious grants, and a bounded response deadline per request. It uses an earliest-deadline-first (EDF) fallback and an optional sticky recovery phase after each deviation.

## Interface
Parameters:
- N, 2: channel count, 1..8.
- DEADLINE, 3: maximum cycles from request to grant, inclusive of the request cycle. Elaboration error if DEADLINE < N or DEADLINE > 15.
- RECOVER_CYC, 2: cycles of forced EDF after a deviation. 0 means pure per-cycle minimal interference.
- CNT_W, 16: width of the deviation counter.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req  in  N  environment requests.
- sys_grant  in  N  grants proposed by the system.
- shd_grant  out  N  grants issued to the plant.
- deviate  out  1  high when shd_grant != sys_grant.
- recovering  out  1  high while in RECOVER.
- dev_cnt  out  CNT_W  present only with SHIELD_STATS_EN.

## Operation
- Per-channel state: pend[i] (1 bit) and slack[i] (SW = clog2(DEADLINE+1) bits). Slack is the number of cycles, including the current one, in which a grant still meets the deadline.
- Effective values in the current cycle:
  - ep[i] = pend[i] | req[i].
  - es[i] = pend[i] ? slack[i] : DEADLINE.
  - A req on an already pending channel does not re-arm.
- A candidate grant g is legal iff all of the following hold:
  - popcount(g) <= 1.
  - (g & ~ep) == 0.
  - For every k in 0..DEADLINE-1, the number of channels with ep & ~g and es-1 <= k is <= k.
- The last condition is the winning-region check. Because DEADLINE >= N, it guarantees future feasibility.
- EDF pick: the ep channel with minimum es, ties to the lowest index; all-zero if no channel has ep set. The EDF pick is always legal.
- FSM states ST_PASS and ST_RECOVER:
  - ST_PASS: shd_grant = sys_grant if legal, else the EDF pick. On deviation with RECOVER_CYC > 0, go to ST_RECOVER and load rcnt = RECOVER_CYC.
  - ST_RECOVER: shd_grant = EDF pick regardless of sys_grant. rcnt decrements each cycle; when rcnt == 1, return to ST_PASS.
- State update from shd_grant:
  - Granted channel: pend = 0.
  - Channel with ep set and not granted: pend = 1, slack = es-1.
  - Otherwise: pend = 0.
- dev_cnt increments on each cycle with deviate = 1 and saturates at all-ones.

## Timing
- shd_grant, deviate and recovering are combinational from inputs and registered state, with zero latency. State updates on the rising edge of clock.
- While reset is high:
  - shd_grant = 0, deviate = 0, recovering = 0.
  - On the edge: pend = 0, slack = 0, state ST_PASS, rcnt = 0, dev_cnt = 0.
- Reset mid-operation drops all pending obligations and any RECOVER phase.
- A request and a grant in the same cycle satisfy the request immediately.
- A deviation while already in ST_RECOVER does not reload rcnt.
- ST_RECOVER lasts exactly RECOVER_CYC cycles, starting the cycle after the triggering deviation.
- Invariant checked by assertion: slack[i] >= 1 whenever pend[i] = 1.

## Configuration
- SHIELD_STATS_EN defined: the dev_cnt port and its saturating counter are present.
- SHIELD_STATS_EN undefined: dev_cnt port and counter are absent. All other behaviour is identical.

## Structure
- Package shield_pkg holds:
  - the state enum {ST_PASS, ST_RECOVER};
  - a clog2 function;
  - the MAX_N = 8 and MAX_DEADLINE = 15 bounds.
- Sub-module shield_edf_pick: combinational min-slack selector. Inputs are ep and the es vector; output is a one-hot or zero grant.

## Test plan
- Idle after reset (N=2, D=3, RC=2): req=00, sys=00 → shd=00, deviate=0, recovering=0.
- Mutex violation: req=11, sys=11 → shd=01, deviate=1; recovering=1 for the next 2 cycles, then 0.
- Spurious grant: no pending, req=00, sys=10 → shd=00, deviate=1.
- Deadline enforcement (RC=0): req=01 in cycle 0 only, sys=00 in cycles 0..2 → shd=00 in cycles 0 and 1 (deviate=0); shd=01 with deviate=1 in cycle 2.
- Lookahead (N=2, D=2): req=11, sys=00 → next slacks 1 and 1 violate k=1, so shd=01, deviate=1; next cycle shd=10.
- Reset mid-RECOVER, then stats (SHIELD_STATS_EN, CNT_W=2):
  - Assert reset in ST_RECOVER → recovering=0 next cycle and pend cleared.
  - Then drive 5 consecutive deviating cycles → dev_cnt=3 (saturated).

Source files
------------

// File: rtl/shield_pkg.sv
// Shared types, bounds and helpers for the shield_edf_n runtime safety shield.
package shield_pkg;

  localparam int MAX_N        = 8;
  localparam int MAX_DEADLINE = 15;

  typedef enum logic [0:0] {
    ST_PASS    = 1'b0,
    ST_RECOVER = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] popcount8(input logic [MAX_N-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < MAX_N; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/shield_edf_n_chk.sv
// Invariant checker for shield_edf_n: a pending channel always has slack left.
module shield_edf_n_chk #(
  parameter int N  = 2,
  parameter int SW = 2
) (
  input logic                 clock,
  input logic                 reset,
  input logic [N-1:0]         pend,
  input logic [N-1:0][SW-1:0] slack
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    a_slack_pos: assert property (@(posedge clock) disable iff (reset)
      pend[i] |-> (slack[i] != '0));
  end

endmodule

// File: rtl/shield_edf_pick.sv
// Earliest-deadline-first selector: one-hot grant to the active channel with the
// smallest slack, ties to the lowest index, all-zero when nothing is active.
module shield_edf_pick
  import shield_pkg::*;
#(
  parameter int N  = 2,
  parameter int SW = 2
) (
  input  logic [N-1:0]         ep,
  input  logic [N-1:0][SW-1:0] es,
  output logic [N-1:0]         grant
);

  logic [SW-1:0] best_s;
  logic          found_s;

  // Linear scan; strict less-than keeps the lowest index on ties
  always_comb begin
    grant   = '0;
    best_s  = '1;
    found_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (ep[i] && (!found_s || (es[i] < best_s))) begin
        found_s  = 1'b1;
        best_s   = es[i];
        grant    = '0;
        grant[i] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/shield_edf_n.sv
// N-channel mutex/no-spurious/deadline shield with EDF fallback and sticky recovery.
// Define SHIELD_STATS_EN to add the saturating dev_cnt deviation counter port.
module shield_edf_n
  import shield_pkg::*;
#(
  parameter int N           = 2,
  parameter int DEADLINE    = 3,
  parameter int RECOVER_CYC = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     sys_grant,
  output logic [N-1:0]     shd_grant,
  output logic             deviate,
  output logic             recovering
`ifdef SHIELD_STATS_EN
  ,
  output logic [CNT_W-1:0] dev_cnt
`endif
);

  localparam int SW = clog2(DEADLINE + 1);
  localparam int RW = clog2(RECOVER_CYC + 2);

  if (N < 1 || N > MAX_N || DEADLINE < N || DEADLINE > MAX_DEADLINE || CNT_W < 1)
  begin : g_param_err
    $error("shield_edf_n: illegal N/DEADLINE/CNT_W combination");
  end

  logic [N-1:0]         pend_r;
  logic [N-1:0][SW-1:0] slack_r;
  state_e               state_r;
  logic [RW-1:0]        rcnt_r;

  logic [N-1:0]         ep_s;
  logic [N-1:0][SW-1:0] es_s;
  logic [N-1:0]         edf_s;
  logic                 legal_s;
  logic [N-1:0]         shd_s;
  logic                 dev_s;

  // Effective pending/slack: a fresh request starts with the full deadline
  always_comb begin
    ep_s = pend_r | req;
    es_s = '0;
    for (int i = 0; i < N; i++) begin
      if (pend_r[i]) begin
        es_s[i] = slack_r[i];
      end else begin
        es_s[i] = SW'(DEADLINE);
      end
    end
  end

  shield_edf_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .ep    (ep_s),
    .es    (es_s),
    .grant (edf_s)
  );

  // Legality of the proposed grant; the window sweep keeps every future deadline reachable
  always_comb begin
    logic [3:0] cnt_v;
    cnt_v   = 4'd0;
    legal_s = (popcount8(MAX_N'(sys_grant)) <= 4'd1) && ((sys_grant & ~ep_s) == '0);
    for (int k = 0; k < DEADLINE; k++) begin
      cnt_v = 4'd0;
      for (int i = 0; i < N; i++) begin
        if (ep_s[i] && !sys_grant[i] && (es_s[i] <= SW'(k + 1))) begin
          cnt_v = cnt_v + 4'd1;
        end else begin
          cnt_v = cnt_v;
        end
      end
      if (cnt_v > 4'(k)) begin
        legal_s = 1'b0;
      end else begin
        legal_s = legal_s;
      end
    end
  end

  // Output selection: pass-through when legal in PASS, otherwise EDF
  always_comb begin
    shd_s = '0;
    dev_s = 1'b0;
    if (reset) begin
      shd_s = '0;
      dev_s = 1'b0;
    end else if (state_r == ST_RECOVER) begin
      shd_s = edf_s;
      dev_s = (edf_s != sys_grant);
    end else if (legal_s) begin
      shd_s = sys_grant;
      dev_s = 1'b0;
    end else begin
      shd_s = edf_s;
      dev_s = (edf_s != sys_grant);
    end
  end

  assign shd_grant  = shd_s;
  assign deviate    = dev_s;
  assign recovering = !reset && (state_r == ST_RECOVER);

  // Obligation tracking and recovery FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_r  <= '0;
      slack_r <= '0;
      state_r <= ST_PASS;
      rcnt_r  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (shd_s[i]) begin
          pend_r[i]  <= 1'b0;
          slack_r[i] <= '0;
        end else if (ep_s[i]) begin
          pend_r[i]  <= 1'b1;
          slack_r[i] <= es_s[i] - SW'(1);
        end else begin
          pend_r[i]  <= 1'b0;
          slack_r[i] <= '0;
        end
      end
      case (state_r)
        ST_PASS: begin
          if (dev_s && (RECOVER_CYC > 0)) begin
            state_r <= ST_RECOVER;
            rcnt_r  <= RW'(RECOVER_CYC);
          end else begin
            state_r <= ST_PASS;
            rcnt_r  <= '0;
          end
        end
        ST_RECOVER: begin
          if (rcnt_r <= RW'(1)) begin
            state_r <= ST_PASS;
            rcnt_r  <= '0;
          end else begin
            state_r <= ST_RECOVER;
            rcnt_r  <= rcnt_r - RW'(1);
          end
        end
        default: begin
          state_r <= ST_PASS;
          rcnt_r  <= '0;
        end
      endcase
    end
  end

`ifdef SHIELD_STATS_EN
  logic [CNT_W-1:0] dev_cnt_r;

  // Saturating count of deviating cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      dev_cnt_r <= '0;
    end else if (dev_s && (dev_cnt_r != '1)) begin
      dev_cnt_r <= dev_cnt_r + CNT_W'(1);
    end else begin
      dev_cnt_r <= dev_cnt_r;
    end
  end

  assign dev_cnt = dev_cnt_r;
`endif

  shield_edf_n_chk #(
    .N  (N),
    .SW (SW)
  ) u_chk (
    .clock (clock),
    .reset (reset),
    .pend  (pend_r),
    .slack (slack_r)
  );

endmodule

// File: tb/tb_shield_edf_n.sv
// Directed self-checking bench for shield_edf_n using three parameterisations.
module tb_shield_edf_n;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_a, rst_b, rst_c;
  logic [1:0] req_a, sys_a, shd_a;
  logic [1:0] req_b, sys_b, shd_b;
  logic [1:0] req_c, sys_c, shd_c;
  logic       dev_a, rec_a, dev_b, rec_b, dev_c, rec_c;
`ifdef SHIELD_STATS_EN
  logic [1:0]  cnt_a;
  logic [15:0] cnt_b, cnt_c;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  shield_edf_n #(.N(2), .DEADLINE(3), .RECOVER_CYC(2), .CNT_W(2)) u_a (
    .clock (clock), .reset (rst_a), .req (req_a), .sys_grant (sys_a),
    .shd_grant (shd_a), .deviate (dev_a), .recovering (rec_a)
`ifdef SHIELD_STATS_EN
    , .dev_cnt (cnt_a)
`endif
  );

  shield_edf_n #(.N(2), .DEADLINE(3), .RECOVER_CYC(0), .CNT_W(16)) u_b (
    .clock (clock), .reset (rst_b), .req (req_b), .sys_grant (sys_b),
    .shd_grant (shd_b), .deviate (dev_b), .recovering (rec_b)
`ifdef SHIELD_STATS_EN
    , .dev_cnt (cnt_b)
`endif
  );

  shield_edf_n #(.N(2), .DEADLINE(2), .RECOVER_CYC(2), .CNT_W(16)) u_c (
    .clock (clock), .reset (rst_c), .req (req_c), .sys_grant (sys_c),
    .shd_grant (shd_c), .deviate (dev_c), .recovering (rec_c)
`ifdef SHIELD_STATS_EN
    , .dev_cnt (cnt_c)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs to one instance just after the falling edge, then settle
  task automatic drive(input int which, input logic [1:0] r, input logic [1:0] s);
    @(negedge clock);
    case (which)
      0: begin req_a = r; sys_a = s; end
      1: begin req_b = r; sys_b = s; end
      default: begin req_c = r; sys_c = s; end
    endcase
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [1:0] shd, input logic dev, input logic rec);
    check_eq({tag, ".shd"}, {30'd0, shd_a}, {30'd0, shd});
    check_eq({tag, ".dev"}, {31'd0, dev_a}, {31'd0, dev});
    check_eq({tag, ".rec"}, {31'd0, rec_a}, {31'd0, rec});
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    req_a = 2'b00; sys_a = 2'b00;
    req_b = 2'b00; sys_b = 2'b00;
    req_c = 2'b00; sys_c = 2'b00;

    // Outputs forced quiet while reset is high
    drive(0, 2'b11, 2'b11);
    chk_a("in_reset", 2'b00, 1'b0, 1'b0);
    @(negedge clock);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    req_a = 2'b00; sys_a = 2'b00;
    #1;
    chk_a("idle", 2'b00, 1'b0, 1'b0);

    // Instance A: mutex violation then two recovery cycles
    drive(0, 2'b11, 2'b11); chk_a("mutex", 2'b01, 1'b1, 1'b0);
    drive(0, 2'b00, 2'b00); chk_a("rec1", 2'b10, 1'b1, 1'b1);
    drive(0, 2'b00, 2'b00); chk_a("rec2", 2'b00, 1'b0, 1'b1);
    drive(0, 2'b01, 2'b01); chk_a("pass", 2'b01, 1'b0, 1'b0);
    drive(0, 2'b00, 2'b10); chk_a("spurious", 2'b00, 1'b1, 1'b0);
    drive(0, 2'b00, 2'b00); chk_a("sp_rec1", 2'b00, 1'b0, 1'b1);
    drive(0, 2'b00, 2'b00); chk_a("sp_rec2", 2'b00, 1'b0, 1'b1);
    drive(0, 2'b11, 2'b11); chk_a("mutex2", 2'b01, 1'b1, 1'b0);

    // Reset while recovering with channel 1 still pending
    @(negedge clock);
    rst_a = 1'b1; req_a = 2'b00; sys_a = 2'b00;
    #1;
    chk_a("rst_rec", 2'b00, 1'b0, 1'b0);
    @(negedge clock);
    rst_a = 1'b0; req_a = 2'b00; sys_a = 2'b10;
    #1;
    // A surviving pend[1] would make sys=10 legal
    chk_a("pend_clr", 2'b00, 1'b1, 1'b0);
`ifdef SHIELD_STATS_EN
    check_eq("cnt0", {30'd0, cnt_a}, 32'd0);
`endif
    drive(0, 2'b00, 2'b11);
`ifdef SHIELD_STATS_EN
    check_eq("cnt1", {30'd0, cnt_a}, 32'd1);
`endif
    drive(0, 2'b00, 2'b11);
`ifdef SHIELD_STATS_EN
    check_eq("cnt2", {30'd0, cnt_a}, 32'd2);
`endif
    drive(0, 2'b00, 2'b11);
    check_eq("dev_any", {31'd0, dev_a}, 32'd1);
    drive(0, 2'b00, 2'b11);
    drive(0, 2'b00, 2'b00);
    check_eq("dev_idle", {31'd0, dev_a}, 32'd0);
`ifdef SHIELD_STATS_EN
    check_eq("cnt_sat", {30'd0, cnt_a}, 32'd3);
`endif

    // Instance B: deadline enforcement with no recovery phase
    drive(1, 2'b01, 2'b00);
    check_eq("dl0.shd", {30'd0, shd_b}, 32'd0);
    check_eq("dl0.dev", {31'd0, dev_b}, 32'd0);
    drive(1, 2'b00, 2'b00);
    check_eq("dl1.shd", {30'd0, shd_b}, 32'd0);
    check_eq("dl1.dev", {31'd0, dev_b}, 32'd0);
    drive(1, 2'b00, 2'b00);
    check_eq("dl2.shd", {30'd0, shd_b}, 32'd1);
    check_eq("dl2.dev", {31'd0, dev_b}, 32'd1);
    check_eq("dl2.rec", {31'd0, rec_b}, 32'd0);
    drive(1, 2'b00, 2'b00);
    check_eq("dl3.rec", {31'd0, rec_b}, 32'd0);
    check_eq("dl3.shd", {30'd0, shd_b}, 32'd0);

    // Instance C: legal pass-through then lookahead violation
    drive(2, 2'b11, 2'b10);
    check_eq("la_ok0.shd", {30'd0, shd_c}, 32'd2);
    check_eq("la_ok0.dev", {31'd0, dev_c}, 32'd0);
    drive(2, 2'b00, 2'b01);
    check_eq("la_ok1.shd", {30'd0, shd_c}, 32'd1);
    check_eq("la_ok1.dev", {31'd0, dev_c}, 32'd0);
    drive(2, 2'b11, 2'b00);
    check_eq("la0.shd", {30'd0, shd_c}, 32'd1);
    check_eq("la0.dev", {31'd0, dev_c}, 32'd1);
    drive(2, 2'b00, 2'b00);
    check_eq("la1.shd", {30'd0, shd_c}, 32'd2);
    check_eq("la1.rec", {31'd0, rec_c}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
